// File: rtl/bsg_fifo_1r1w_small_hardened_rr_ctrl_pkg.sv
// Shared helpers for the round-robin write-side scheduler of the small hardened FIFO.
// Latency: n/a (elaboration-time helpers only).
// Backpressure: n/a.
package bsg_fifo_1r1w_small_hardened_rr_ctrl_pkg;

  // Width of an index able to address n items; never returns zero so that
  // degenerate parameterisations still produce legal vectors.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_rr_ctrl_arb.sv
// Round-robin picker: first eligible index at or after ptr, wrapping modulo num_src_p.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; an empty elig vector simply yields no grant.
//
// Ports:
//   elig   in  num_src_p    sources allowed to win this cycle
//   ptr    in  tag_width_p  index with highest priority this cycle (< num_src_p)
//   grant  out num_src_p    one-hot winner, all zero when elig is empty
//   winner out tag_width_p  binary index of the winner (0 when no grant)
module bsg_fifo_rr_ctrl_arb #(
  parameter int num_src_p   = 4,
  parameter int tag_width_p = 2
) (
  input  logic [num_src_p-1:0]   elig,
  input  logic [tag_width_p-1:0] ptr,
  output logic [num_src_p-1:0]   grant,
  output logic [tag_width_p-1:0] winner
);

  // One extra bit so ptr+k cannot overflow before the modulo fold.
  localparam int sum_width_lp = tag_width_p + 1;

  logic [sum_width_lp-1:0] idx;

  // Walk the offsets from farthest to nearest; the last hit is the source
  // closest to ptr in rotation order, which is the round-robin winner.
  // The fold is a single conditional subtract, so it stays correct when
  // num_src_p is not a power of two.
  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    for (int k = num_src_p - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + sum_width_lp'(k);
      if (idx >= sum_width_lp'(num_src_p)) begin
        idx = idx - sum_width_lp'(num_src_p);
      end
      for (int i = 0; i < num_src_p; i++) begin
        if (elig[i] && (idx == sum_width_lp'(i))) begin
          grant    = '0;
          grant[i] = 1'b1;
          winner   = tag_width_p'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small_hardened_rr_ctrl.sv
// Write-side scheduler sharing one small hardened FIFO among num_src_p requesters with per-source quotas.
// Latency: grant and FIFO write are combinational (zero cycles); occupancy/quota outputs are registered.
// Backpressure: no grant while fifo_ready_i is low; a source at quota is held off until its registered count drops.
//
// Ports:
//   clk_i          in  1                       clock, posedge
//   reset_n_i      in  1                       async active-low reset
//   v_i            in  num_src_p               per-source request valid
//   data_i         in  num_src_p*width_p       per-source payload, source i at [i*width_p +: width_p]
//   ready_and_o    out num_src_p               one-hot grant
//   fifo_v_o       out 1                       FIFO write valid
//   fifo_data_o    out tag_width_lp+width_p    {source tag, payload}
//   fifo_ready_i   in  1                       FIFO can accept a write
//   fifo_deq_i     in  1                       FIFO dequeues this cycle
//   fifo_deq_src_i in  tag_width_lp            tag field of the dequeued entry
//   src_cnt_o      out num_src_p*cnt_width_lp  per-source occupancy (registered)
//   src_at_quota_o out num_src_p               per-source count == quota (registered)
module bsg_fifo_1r1w_small_hardened_rr_ctrl
  import bsg_fifo_1r1w_small_hardened_rr_ctrl_pkg::*;
#(
  parameter  int width_p      = 8,
  parameter  int num_src_p    = 4,
  parameter  int els_p        = 8,
  parameter  int src_quota_p  = els_p / 2,
  localparam int tag_width_lp = safe_clog2(num_src_p),
  localparam int cnt_width_lp = safe_clog2(src_quota_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_src_p-1:0]              v_i,
  input  logic [num_src_p*width_p-1:0]      data_i,
  output logic [num_src_p-1:0]              ready_and_o,
  output logic                              fifo_v_o,
  output logic [tag_width_lp+width_p-1:0]   fifo_data_o,
  input  logic                              fifo_ready_i,
  input  logic                              fifo_deq_i,
  input  logic [tag_width_lp-1:0]           fifo_deq_src_i,
  output logic [num_src_p*cnt_width_lp-1:0] src_cnt_o,
  output logic [num_src_p-1:0]              src_at_quota_o
);

  // Parameter sanity, caught at elaboration.
  if (num_src_p < 2) begin : g_bad_num_src
    $error("bsg_fifo_1r1w_small_hardened_rr_ctrl: num_src_p must be at least 2");
  end
  if ((src_quota_p < 1) || (src_quota_p > els_p)) begin : g_bad_quota
    $error("bsg_fifo_1r1w_small_hardened_rr_ctrl: src_quota_p must lie in 1..els_p");
  end

  localparam logic [cnt_width_lp-1:0] quota_lp = cnt_width_lp'(src_quota_p);
  localparam logic [tag_width_lp-1:0] last_lp  = tag_width_lp'(num_src_p - 1);

  logic [tag_width_lp-1:0] ptr_r;
  logic [tag_width_lp-1:0] ptr_n;
  logic [cnt_width_lp-1:0] cnt_r [num_src_p];
  logic [cnt_width_lp-1:0] cnt_n [num_src_p];
  logic [num_src_p-1:0]    at_quota_r;
  logic [num_src_p-1:0]    at_quota_n;

  logic [num_src_p-1:0]    elig;
  logic [num_src_p-1:0]    grant;
  logic [tag_width_lp-1:0] winner;
  logic [width_p-1:0]      payload;
  logic [num_src_p-1:0]    enq;
  logic [num_src_p-1:0]    deq;

  // Quota is taken from the registered flag only, so a dequeue in this cycle
  // cannot reach the grant path; the freed slot becomes usable next cycle.
  // Gating with reset_n_i keeps all grants off while reset is held.
  assign elig = v_i & ~at_quota_r & {num_src_p{fifo_ready_i & reset_n_i}};

  bsg_fifo_rr_ctrl_arb #(
    .num_src_p   (num_src_p),
    .tag_width_p (tag_width_lp)
  ) arb (
    .elig   (elig),
    .ptr    (ptr_r),
    .grant  (grant),
    .winner (winner)
  );

  assign ready_and_o = grant;
  assign fifo_v_o    = |elig;

  // One-hot select of the winning payload.
  always_comb begin
    payload = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (grant[i]) begin
        payload = data_i[i*width_p +: width_p];
      end
    end
  end

  assign fifo_data_o = {winner, payload};

  // Next pointer: one past the winner, explicit wrap for any num_src_p.
  always_comb begin
    ptr_n = ptr_r;
    if (|grant) begin
      ptr_n = (winner == last_lp) ? '0 : winner + 1'b1;
    end
  end

  // Per-source occupancy. Simultaneous enqueue and dequeue cancel. A dequeue
  // of a source already at zero is a protocol error and leaves the count at
  // zero. Out-of-range tags never match any source and are ignored.
  always_comb begin
    enq        = '0;
    deq        = '0;
    at_quota_n = '0;
    for (int i = 0; i < num_src_p; i++) begin
      enq[i]   = grant[i];
      deq[i]   = fifo_deq_i && (fifo_deq_src_i == tag_width_lp'(i));
      cnt_n[i] = cnt_r[i];
      if (enq[i] && !deq[i]) begin
        cnt_n[i] = cnt_r[i] + 1'b1;
      end else if (deq[i] && !enq[i] && (cnt_r[i] != '0)) begin
        cnt_n[i] = cnt_r[i] - 1'b1;
      end
      at_quota_n[i] = (cnt_n[i] == quota_lp);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r      <= '0;
      at_quota_r <= '0;
      for (int i = 0; i < num_src_p; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      ptr_r      <= ptr_n;
      at_quota_r <= at_quota_n;
      for (int i = 0; i < num_src_p; i++) begin
        cnt_r[i] <= cnt_n[i];
      end
    end
  end

  always_comb begin
    src_cnt_o = '0;
    for (int i = 0; i < num_src_p; i++) begin
      src_cnt_o[i*cnt_width_lp +: cnt_width_lp] = cnt_r[i];
    end
  end

  assign src_at_quota_o = at_quota_r;

`ifndef SYNTHESIS
  // Read-side protocol errors; the datapath above already tolerates them.
  always @(negedge clk_i) begin
    if (reset_n_i && fifo_deq_i) begin
      if (int'(fifo_deq_src_i) >= num_src_p) begin
        $error("rr_ctrl: dequeue tag %0d is not a valid source", fifo_deq_src_i);
      end else if (cnt_r[fifo_deq_src_i] == '0) begin
        $error("rr_ctrl: dequeue from source %0d whose count is zero", fifo_deq_src_i);
      end
    end
  end
`endif

endmodule

// File: doc/bsg_fifo_1r1w_small_hardened_rr_ctrl.md
Name: bsg_fifo_1r1w_small_hardened_rr_ctrl

Overview:
Write-side scheduler that shares one bsg_fifo_1r1w_small_hardened among num_src_p requesters.
- Picks one requester per cycle by round-robin and appends a source tag to the data.
- Enforces a per-source occupancy quota so that no single source can fill the shared FIFO.
- Tracks per-source occupancy from the FIFO's dequeue stream. The block sits between the requesters and the FIFO write port; it does not contain the FIFO.

Parameters:
width_p, (required), payload width per requester
num_src_p, 4, number of requesters, ≥2
els_p, 8, depth of the downstream FIFO
src_quota_p, els_p/2, max entries one source may hold in the FIFO, 1..els_p
tag_width_lp, `BSG_SAFE_CLOG2(num_src_p), local, source tag width
cnt_width_lp, `BSG_SAFE_CLOG2(src_quota_p+1), local, occupancy counter width

Ports:
clk_i  in  1  clock, posedge
reset_n_i  in  1  reset, asynchronous assert, active-low
v_i  in  num_src_p  per-source request valid (valid-and-ready)
data_i  in  num_src_p*width_p  per-source payload; source i at bits [i*width_p +: width_p]
ready_and_o  out  num_src_p  one-hot grant; the transfer occurs when v_i[i]&ready_and_o[i]
fifo_v_o  out  1  FIFO write valid
fifo_data_o  out  tag_width_lp+width_p  {src_tag, payload}, tag in the MSBs
fifo_ready_i  in  1  FIFO ready_param_o
fifo_deq_i  in  1  FIFO yumi (dequeue this cycle)
fifo_deq_src_i  in  tag_width_lp  tag field of the dequeued FIFO data_o
src_cnt_o  out  num_src_p*cnt_width_lp  per-source occupancy, registered
src_at_quota_o  out  num_src_p  cnt==src_quota_p, registered

Behaviour:
- State:
  - rr pointer ptr_r (tag_width_lp bits)
  - cnt_r[num_src_p]
  - All state is cleared asynchronously when reset_n_i=0: ptr_r=0, all cnt_r=0.
- Outputs while reset_n_i=0:
  - ready_and_o=0, fifo_v_o=0.
  - src_cnt_o=0, src_at_quota_o=0.
  - fifo_data_o is don't-care.
- Eligibility: elig[i] = v_i[i] & ~src_at_quota_o[i] & fifo_ready_i & reset_n_i.
- Arbitration is combinational with zero latency.
  - The winner is the first elig index scanning ptr_r, ptr_r+1, …, wrapping modulo num_src_p.
  - ready_and_o = onehot(winner), or 0 if there is no eligible source.
  - fifo_v_o = |elig.
  - fifo_data_o = {winner tag, data_i[winner]}.
- Pointer update: on any grant, ptr_r <= (winner+1) mod num_src_p. With no grant, ptr_r holds.
  - The wrap must be correct for num_src_p not a power of two.
- Counters, evaluated per source i each cycle:
  - enq_i = ready_and_o[i] (a grant implies v_i[i]).
  - deq_i = fifo_deq_i & (fifo_deq_src_i==i).
  - enq_i & deq_i: cnt holds.
  - enq_i only: cnt+1.
  - deq_i only: cnt-1.
- Quota is evaluated from the registered count only.
  - A same-cycle dequeue does NOT unblock a source that is at quota; the source becomes eligible in the next cycle.
  - This keeps the FIFO read side out of the write-side combinational path.
- Consistency: sum of cnt_r equals the FIFO occupancy at all times.
  - src_quota_p=els_p means the quota never binds before fifo_ready_i deasserts.
- Boundary errors (report in a non-synthesis negedge block; the RTL still acts as stated):
  - Dequeue from a source with cnt 0: cnt stays 0, print error.
  - fifo_deq_src_i ≥ num_src_p: ignored, print error.
- Handshake: a requester must hold v_i and data_i until granted. The arbiter never re-grants a source out of its rr order.
- Reset mid-operation: counters clear instantly. The integrator must reset the FIFO in the same window; otherwise the counts are undefined.
- Starvation bound: a continuously valid, under-quota source is granted within num_src_p grants.

Decomposition:
- No package is needed; the tag and count widths are local params.
- One sub-module: bsg_fifo_rr_ctrl_arb.
  - Inputs: elig vector, ptr_r.
  - Outputs: one-hot grant and binary winner tag.
  - Purely combinational.
- The top holds ptr_r, the counters and the payload mux.

Test Plan:
1. Reset: hold reset_n_i=0 with all v_i=1 → ready_and_o=0, fifo_v_o=0. Release, num_src_p=4 → grants go 0,1,2,3,0 on consecutive cycles.
2. Quota: src_quota_p=2, only src 2 valid, no deq → 2 grants, then src_at_quota_o[2]=1 and ready_and_o[2]=0. Dequeue tag 2 → grant on the following cycle, not the same cycle.
3. Simultaneous enq and deq of src 1 at cnt=1 → cnt stays 1. Enq src 0 with deq src 3 → cnt0+1, cnt3-1.
4. fifo_ready_i=0 with all valid → no grants and ptr_r unchanged. Ready returns → the grant goes to the source at the old ptr_r.
5. num_src_p=3, sources 1 and 2 valid → ptr wraps 2→0, grants alternate 1,2,1,2; tag field in fifo_data_o matches.
6. Random traffic against the FIFO model for 10k cycles → sum of src_cnt_o equals FIFO occupancy every cycle; no error prints.
